// File: rtl/icap_7series_pkg.sv
// rtl/icap_7series_pkg.sv - 7-series ICAP command words, multiboot FSM states and word helpers
package icap_7series_pkg;

  localparam logic [31:0] ICAP_DUMMY         = 32'hFFFF_FFFF;
  localparam logic [31:0] ICAP_SYNC          = 32'hAA99_5566;
  localparam logic [31:0] ICAP_NOP           = 32'h2000_0000;
  localparam logic [31:0] ICAP_HDR_WBSTAR_W1 = 32'h3002_0001;
  localparam logic [31:0] ICAP_HDR_CMD_W1    = 32'h3000_8001;
  localparam logic [31:0] ICAP_CMD_IPROG     = 32'h0000_000F;
  localparam logic [31:0] ICAP_CMD_DESYNC    = 32'h0000_000D;
  localparam logic [31:0] ICAP_HDR_IDCODE_R1 = 32'h2801_8001;

  // Index one past the last word of the reboot sequence.
  localparam logic [3:0] MB_SEQ_END = 4'd10;

  typedef enum logic [1:0] {
    ST_BOOT_HOLD,
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } mb_state_t;

  // ICAPE2 expects each byte bit-reversed relative to the bitstream word.
  function automatic logic [31:0] icap_bitswap(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b+i] = w[8*b+7-i];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mb_word(input logic [3:0] idx, input logic [31:0] wbstar);
    logic [31:0] w;
    case (idx)
      4'd0:    w = ICAP_DUMMY;
      4'd1:    w = ICAP_SYNC;
      4'd4:    w = ICAP_HDR_WBSTAR_W1;
      4'd5:    w = wbstar;
      4'd6:    w = ICAP_HDR_CMD_W1;
      4'd7:    w = ICAP_CMD_IPROG;
      default: w = ICAP_NOP;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/icap_wrapper_7series.sv
// rtl/icap_wrapper_7series.sv - ICAPE2 instance with per-byte bit-swap on I and O
module icap_wrapper_7series
  import icap_7series_pkg::*;
(
  input  logic        clk,
  input  logic        cs_n,
  input  logic        wr_n,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  logic [31:0] w_i_sw;
  logic [31:0] w_o_sw;

  assign w_i_sw = icap_bitswap(din);
  assign dout   = icap_bitswap(w_o_sw);

`ifdef SYNTHESIS
  (* LOC = "ICAP_X0Y1" *)
  ICAPE2 #(
    .ICAP_WIDTH ("X32")
  ) u_icape2 (
    .CLK   (clk),
    .CSIB  (cs_n),
    .RDWRB (wr_n),
    .I     (w_i_sw),
    .O     (w_o_sw)
  );
`else
  // Behavioural stand-in: loops back the last written word.
  logic [31:0] r_o_sw;
  always_ff @(posedge clk) begin
    if (!cs_n && !wr_n) r_o_sw <= w_i_sw;
  end
  assign w_o_sw = r_o_sw;
`endif

endmodule

// File: rtl/icap_multiboot_7series.sv
// rtl/icap_multiboot_7series.sv - warm reboot via WBSTAR + IPROG written through ICAPE2
module icap_multiboot_7series
  import icap_7series_pkg::*;
#(
  parameter logic [23:0] BOOT_HOLD_CYCLES = 24'hffffff,
  parameter logic [31:0] WBSTAR_CTRL      = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reboot_en,
  input  logic [31:0] reboot_addr,
  output logic        ready,
  output logic        busy,
  output logic        done
);

  mb_state_t   r_state;
  logic [23:0] r_hold_cnt;
  logic [3:0]  r_idx;
  logic [31:0] r_wbstar;
  logic        r_cs_n;
  logic        r_wr_n;
  logic [31:0] r_din;
  logic        r_ready;
  logic        r_busy;
  logic        r_done;
  logic [31:0] w_unused_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_BOOT_HOLD;
      r_hold_cnt <= '0;
      r_idx      <= '0;
      r_wbstar   <= '0;
      r_cs_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_din      <= ICAP_DUMMY;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT_HOLD: begin
          if (r_hold_cnt >= BOOT_HOLD_CYCLES) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else if (r_hold_cnt != 24'hffffff) begin
            r_hold_cnt <= r_hold_cnt + 24'd1;
          end
        end
        ST_IDLE: begin
          if (reboot_en) begin
            r_wbstar <= reboot_addr | WBSTAR_CTRL;
            r_state  <= ST_SEND;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_cs_n   <= 1'b0;
            r_wr_n   <= 1'b0;
            r_din    <= ICAP_DUMMY;
            r_idx    <= 4'd1;
          end
        end
        ST_SEND: begin
          if (r_idx == MB_SEQ_END) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_din   <= ICAP_DUMMY;
          end else begin
            r_din <= mb_word(r_idx, r_wbstar);
            r_idx <= r_idx + 4'd1;
          end
        end
        ST_DONE: begin
          // Terminal until reset; in silicon the device reboots here.
        end
        default: r_state <= ST_BOOT_HOLD;
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;

  icap_wrapper_7series u_icap (
    .clk  (clk),
    .cs_n (r_cs_n),
    .wr_n (r_wr_n),
    .din  (r_din),
    .dout (w_unused_dout)
  );

endmodule

// File: tb/tb_icap_multiboot_7series.sv
// tb/tb_icap_multiboot_7series.sv - directed self-checking bench for icap_multiboot_7series
module tb_icap_multiboot_7series;
  import icap_7series_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        reboot_en;
  logic [31:0] addr0, addr1;
  logic        ready0, busy0, done0;
  logic        ready1, busy1, done1;
  logic [31:0] exp_words [10];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  icap_multiboot_7series #(
    .BOOT_HOLD_CYCLES (24'd16),
    .WBSTAR_CTRL      (32'h0)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .reboot_en   (reboot_en),
    .reboot_addr (addr0),
    .ready       (ready0),
    .busy        (busy0),
    .done        (done0)
  );

  icap_multiboot_7series #(
    .BOOT_HOLD_CYCLES (24'd16),
    .WBSTAR_CTRL      (32'h4000_0000)
  ) u_dut_ctrl (
    .clk         (clk),
    .rst         (rst),
    .reboot_en   (reboot_en),
    .reboot_addr (addr1),
    .ready       (ready1),
    .busy        (busy1),
    .done        (done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_hold();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 0; e < 16; e++) begin
      reboot_en = (e == 5);
      tick();
      reboot_en = 1'b0;
      chk($sformatf("hold_ready_e%0d", e), {31'd0, ready0}, 32'd0);
      chk($sformatf("hold_csn_e%0d", e), {31'd0, u_dut.u_icap.cs_n}, 32'd1);
    end
    tick();
    chk("hold_ready_up", {31'd0, ready0}, 32'd1);
    chk("hold_busy_low", {31'd0, busy0}, 32'd0);
  endtask

  task automatic do_seq(input logic [31:0] a, input bit inject);
    exp_words[5] = a;
    addr0 = a;
    addr1 = 32'h0012_3000;
    reboot_en = 1'b1;
    tick();
    reboot_en = 1'b0;
    if (inject) addr0 = 32'hDEAD_BEEF;
    chk("seq_ready_fall", {31'd0, ready0}, 32'd0);
    chk("seq_busy_rise", {31'd0, busy0}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        reboot_en = inject && (k == 3);
        tick();
        reboot_en = 1'b0;
      end
      chk($sformatf("seq_csn_w%0d", k), {31'd0, u_dut.u_icap.cs_n}, 32'd0);
      chk($sformatf("seq_wrn_w%0d", k), {31'd0, u_dut.u_icap.wr_n}, 32'd0);
      chk($sformatf("seq_din_w%0d", k), u_dut.u_icap.din, exp_words[k]);
      if (k == 5) chk("ctrl_din_w5", u_dut_ctrl.u_icap.din, 32'h4012_3000);
    end
    tick();
    chk("end_csn", {31'd0, u_dut.u_icap.cs_n}, 32'd1);
    chk("end_wrn", {31'd0, u_dut.u_icap.wr_n}, 32'd1);
    chk("end_din", u_dut.u_icap.din, 32'hFFFF_FFFF);
    chk("end_done", {31'd0, done0}, 32'd1);
    chk("end_busy", {31'd0, busy0}, 32'd0);
    chk("end_ready", {31'd0, ready0}, 32'd0);
  endtask

  initial begin
    exp_words[0] = 32'hFFFF_FFFF;
    exp_words[1] = 32'hAA99_5566;
    exp_words[2] = 32'h2000_0000;
    exp_words[3] = 32'h2000_0000;
    exp_words[4] = 32'h3002_0001;
    exp_words[5] = 32'h0000_0000;
    exp_words[6] = 32'h3000_8001;
    exp_words[7] = 32'h0000_000F;
    exp_words[8] = 32'h2000_0000;
    exp_words[9] = 32'h2000_0000;

    rst = 1'b1;
    reboot_en = 1'b0;
    addr0 = '0;
    addr1 = '0;
    tick();
    tick();
    chk("rst_ready", {31'd0, ready0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_csn", {31'd0, u_dut.u_icap.cs_n}, 32'd1);
    chk("rst_wrn", {31'd0, u_dut.u_icap.wr_n}, 32'd1);
    chk("rst_din", u_dut.u_icap.din, 32'hFFFF_FFFF);

    do_hold();
    do_seq(32'h0040_0000, 1'b1);

    reboot_en = 1'b1;
    tick();
    reboot_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("done_ign_csn_%0d", i), {31'd0, u_dut.u_icap.cs_n}, 32'd1);
      chk($sformatf("done_ign_done_%0d", i), {31'd0, done0}, 32'd1);
      tick();
    end

    do_hold();
    addr0 = 32'hABCD_0000;
    reboot_en = 1'b1;
    tick();
    reboot_en = 1'b0;
    repeat (4) tick();
    chk("abort_w4", u_dut.u_icap.din, 32'h3002_0001);
    rst = 1'b1;
    tick();
    chk("abort_csn", {31'd0, u_dut.u_icap.cs_n}, 32'd1);
    chk("abort_wrn", {31'd0, u_dut.u_icap.wr_n}, 32'd1);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_state", 32'(u_dut.r_state), 32'(ST_BOOT_HOLD));

    do_hold();
    do_seq(32'h1234_5600, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
